// File: rtl/mul_arb_pkg.sv
// Shared types, widths and the round-robin step used by the multiplier-sharing arbiter.
// Pure declarations; no state.
package mul_arb_pkg;

  localparam int DATA_W   = 16;
  localparam int PROD_W   = 32;
  localparam int NREQ_DEF = 4;
  localparam int ID_W_DEF = 2;
  // Wide enough for any supported requester count (up to 8).
  localparam int IDX_W    = 3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) + 1 >= n) rr_next = '0;
    else                    rr_next = idx + 1'b1;
  endfunction

endpackage

// File: rtl/mul_tc_16_16.sv
// Combinational 16x16 two's-complement multiplier, full 32-bit product.
// Zero latency; no flow control.
module mul_tc_16_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product
);

  assign product = $signed(a) * $signed(b);

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin share of one 16x16 signed multiplier across NREQ requesters, one-slot registered output.
// Product visible the cycle after accept; req_ready all zero while the slot is full and not draining.
module mul_share_arb
  import mul_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [PROD_W-1:0]    rsp_product
);

  slot_state_e       state_q, state_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic              slot_free;
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   scan_idx;
  logic              accept;
  logic [DATA_W-1:0] mul_a, mul_b;
  logic [PROD_W-1:0] mul_product;

  // Gated by rst_n so nothing is offered while reset is held.
  assign slot_free = rst_n & ((state_q == SLOT_EMPTY) | rsp_ready);

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_vld && req_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
      scan_idx = ID_W'(rr_next(IDX_W'(scan_idx), NREQ));
    end
  end

  assign accept = slot_free & gnt_vld;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  assign mul_a = req_a[32'(gnt_idx) * DATA_W +: DATA_W];
  assign mul_b = req_b[32'(gnt_idx) * DATA_W +: DATA_W];

  mul_tc_16_16 u_mul (
    .a       (mul_a),
    .b       (mul_b),
    .product (mul_product)
  );

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL: begin
        if (accept)         state_d = SLOT_FULL;
        else if (rsp_ready) state_d = SLOT_EMPTY;
      end
    endcase
    if (accept) begin
      prod_d = mul_product;
      id_d   = gnt_idx;
      ptr_d  = ID_W'(rr_next(IDX_W'(gnt_idx), NREQ));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      prod_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rsp_valid   = (state_q == SLOT_FULL);
  assign rsp_id      = id_q;
  assign rsp_product = prod_q;

endmodule
